// File: rtl/unpacker_param.sv
// unpacker_param
//   Splits one wide input beat (up to IN_BYTES bytes) into consecutive
//   OUT_BYTES-wide output words. Supports output backpressure, a programmable
//   idle gap after each beat, clamping of oversize byte counts and optional
//   zero padding of the tail word.
//
// Optional build macro:
//   UNPACKER_ZERO_PAD_EN - bytes at or beyond o_vbc in the tail word, and the
//                          whole word while o_val=0, are driven to zero.
//
// Ports:
//   clk      in   single rising-edge clock
//   reset_L  in   asynchronous active-low reset
//   cfg_gap  in   idle cycles after each beat (sampled on last-word handshake)
//   val      in   input beat valid
//   sop/eop  in   start/end of packet markers for the beat
//   vbc      in   valid byte count of the beat
//   data     in   beat data, byte 0 at the LSBs
//   ready    out  beat accepted when val && ready
//   o_val    out  output word valid
//   o_rdy    in   consumer ready
//   o_sop    out  first word of a beat carrying sop
//   o_eop    out  last word of a beat carrying eop
//   o_vbc    out  valid bytes in the current word
//   o_data   out  output word
//   err      out  pulse when an accepted beat has vbc > IN_BYTES
//   idle     out  high while waiting for a beat
//
// state   | meaning
// --------+-------------------------------------------------
// RESET   | one cycle after reset release, nothing accepted
// IDLE    | waiting for a beat, ready=1
// SEND    | emitting words k=0..n-1 of the latched beat
// GAP     | inter-beat idle gap, counter runs down to 1
module unpacker_param #(
    parameter  int IN_BYTES  = 160,
    parameter  int OUT_BYTES = 32,
    parameter  int GAP_W     = 4,
    localparam int NW        = IN_BYTES / OUT_BYTES,
    localparam int VBC_W     = $clog2(IN_BYTES + 1),
    localparam int OVBC_W    = $clog2(OUT_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [GAP_W-1:0]        cfg_gap,
    input  logic                    val,
    input  logic                    sop,
    input  logic                    eop,
    input  logic [VBC_W-1:0]        vbc,
    input  logic [IN_BYTES*8-1:0]   data,
    output logic                    ready,
    output logic                    o_val,
    input  logic                    o_rdy,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic [OVBC_W-1:0]       o_vbc,
    output logic [OUT_BYTES*8-1:0]  o_data,
    output logic                    err,
    output logic                    idle
);

    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int OW = OUT_BYTES * 8;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_sop, w_sop_nxt;
    logic                   r_eop, w_eop_nxt;
    logic [VBC_W-1:0]       r_vbc, w_vbc_nxt;
    logic [IN_BYTES*8-1:0]  r_data, w_data_nxt;
    logic [KW-1:0]          r_k, w_k_nxt;
    logic [GAP_W-1:0]       r_gap, w_gap_nxt;

    logic                   w_send;
    logic                   w_last;
    logic                   w_ready;
    logic                   w_over;
    logic                   w_load;
    logic [VBC_W-1:0]       w_vbc_cl;
    logic [31:0]            w_nwords;
    logic [OVBC_W-1:0]      w_tail;
    logic [OW-1:0]          w_slice;

    // Word count of the latched beat: ceil(vbc_lat / OUT_BYTES).
    assign w_nwords = (32'(r_vbc) + 32'(OUT_BYTES) - 32'd1) / 32'(OUT_BYTES);
    assign w_last   = (32'(r_k) == (w_nwords - 32'd1));
    assign w_tail   = OVBC_W'(32'(r_vbc) - (w_nwords - 32'd1) * 32'(OUT_BYTES));
    assign w_send   = (r_state == ST_SEND);

    assign w_over   = (32'(vbc) > 32'(IN_BYTES));
    assign w_vbc_cl = w_over ? VBC_W'(IN_BYTES) : vbc;

    // In SEND a new beat is taken only in the cycle the last word leaves with
    // no gap configured, which keeps back-to-back beats bubble-free.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_SEND: w_ready = o_rdy && w_last && (cfg_gap == '0);
            default: w_ready = 1'b0;
        endcase
    end

    assign ready  = w_ready;
    assign w_load = val && w_ready && (vbc != '0);
    assign err    = val && w_ready && w_over;
    assign idle   = (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        w_vbc_nxt   = r_vbc;
        w_data_nxt  = r_data;
        w_k_nxt     = r_k;
        w_gap_nxt   = r_gap;

        case (r_state)
            ST_RESET: w_state_nxt = ST_IDLE;
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_SEND: begin
                if (o_rdy) begin
                    if (!w_last) begin
                        w_k_nxt = r_k + KW'(1);
                    end else if (cfg_gap == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_gap_nxt   = cfg_gap;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Acceptance only happens in IDLE or the gap-free last handshake, so
        // it overrides whatever the state logic above decided.
        if (w_load) begin
            w_sop_nxt   = sop;
            w_eop_nxt   = eop;
            w_vbc_nxt   = w_vbc_cl;
            w_data_nxt  = data;
            w_k_nxt     = '0;
            w_state_nxt = ST_SEND;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_RESET;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_vbc   <= '0;
            r_data  <= '0;
            r_k     <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
            r_vbc   <= w_vbc_nxt;
            r_data  <= w_data_nxt;
            r_k     <= w_k_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    assign w_slice = r_data[OW*int'(r_k) +: OW];

    assign o_val = w_send;
    assign o_sop = w_send && (r_k == '0) && r_sop;
    assign o_eop = w_send && w_last && r_eop;
    assign o_vbc = !w_send ? '0 : (w_last ? w_tail : OVBC_W'(OUT_BYTES));

`ifdef UNPACKER_ZERO_PAD_EN
    always_comb begin
        o_data = '0;
        if (w_send) begin
            for (int b = 0; b < OUT_BYTES; b++) begin
                if (b < int'(o_vbc)) begin
                    o_data[b*8 +: 8] = w_slice[b*8 +: 8];
                end
            end
        end
    end
`else
    // Raw slice; bytes beyond o_vbc are whatever the beat carried.
    assign o_data = w_slice;
`endif

endmodule

// File: tb/tb_unpacker_param.sv
module tb_unpacker_param;

    localparam int IB  = 160;
    localparam int OB  = 32;
    localparam int GW  = 4;
    localparam int VW  = 8;
    localparam int OVW = 6;
`ifdef UNPACKER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_L = 1'b0;
    logic [GW-1:0]   cfg_gap = '0;
    logic            val = 1'b0;
    logic            sop = 1'b0;
    logic            eop = 1'b0;
    logic [VW-1:0]   vbc = '0;
    logic [IB*8-1:0] data = '0;
    logic            ready;
    logic            o_val;
    logic            o_rdy = 1'b1;
    logic            o_sop;
    logic            o_eop;
    logic [OVW-1:0]  o_vbc;
    logic [OB*8-1:0] o_data;
    logic            err;
    logic            idle;

    int total = 0;
    int bad   = 0;

    unpacker_param dut (
        .clk     (clk),
        .reset_L (reset_L),
        .cfg_gap (cfg_gap),
        .val     (val),
        .sop     (sop),
        .eop     (eop),
        .vbc     (vbc),
        .data    (data),
        .ready   (ready),
        .o_val   (o_val),
        .o_rdy   (o_rdy),
        .o_sop   (o_sop),
        .o_eop   (o_eop),
        .o_vbc   (o_vbc),
        .o_data  (o_data),
        .err     (err),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Beat byte i carries base+i.
    function automatic logic [IB*8-1:0] gen_beat(input logic [7:0] base);
        logic [IB*8-1:0] r;
        for (int i = 0; i < IB; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    // Expected word w of a beat built by gen_beat, with vb valid bytes.
    function automatic logic [OB*8-1:0] exp_word(input logic [7:0] base, input int w, input int vb);
        logic [OB*8-1:0] r;
        for (int j = 0; j < OB; j++)
            r[j*8 +: 8] = (PAD && j >= vb) ? 8'h00 : base + 8'(w*OB + j);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_val, o_sop, o_eop, err, ready, idle} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 000000", {o_val, o_sop, o_eop, err, ready, idle});
        end
        total++;
        if (o_vbc !== '0) begin
            bad++;
            $display("FAIL reset_vbc: got %0d expected 0", o_vbc);
        end
        total++;
        if (o_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0", o_data);
        end
        tick();
        reset_L = 1'b1;
        @(negedge clk);
        total++;
        if ({ready, idle} !== 2'b00) begin
            bad++;
            $display("FAIL reset_state_cycle: got ready/idle %b expected 00", {ready, idle});
        end
        tick();
        @(negedge clk);
        total++;
        if ({ready, idle, o_val} !== 3'b110) begin
            bad++;
            $display("FAIL reset_to_idle: got ready/idle/o_val %b expected 110", {ready, idle, o_val});
        end
    endtask

    task automatic test_full_beat;
        logic [OB*8-1:0] ew;
        tick();
        val = 1'b1; sop = 1'b1; eop = 1'b1; vbc = 8'd160; data = gen_beat(8'h10);
        o_rdy = 1'b1; cfg_gap = '0;
        @(negedge clk);
        total++;
        if ({ready, err} !== 2'b10) begin
            bad++;
            $display("FAIL full_accept: got ready/err %b expected 10", {ready, err});
        end
        tick();
        val = 1'b0; sop = 1'b0; eop = 1'b0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            ew = exp_word(8'h10, w, 32);
            total++;
            if ({o_val, o_sop, o_eop} !== {1'b1, w == 0, w == 4}) begin
                bad++;
                $display("FAIL full_flags w%0d: got val/sop/eop %b expected %b", w, {o_val, o_sop, o_eop}, {1'b1, w == 0, w == 4});
            end
            total++;
            if (o_vbc !== 6'd32) begin
                bad++;
                $display("FAIL full_vbc w%0d: got %0d expected 32", w, o_vbc);
            end
            total++;
            if (o_data !== ew) begin
                bad++;
                $display("FAIL full_data w%0d: got %h expected %h", w, o_data, ew);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({o_val, idle} !== 2'b01) begin
            bad++;
            $display("FAIL full_end: got o_val/idle %b expected 01", {o_val, idle});
        end
    endtask

    task automatic test_tail;
        int evb [3] = '{32, 32, 6};
        logic [OB*8-1:0] ew;
        tick();
        val = 1'b1; sop = 1'b1; eop = 1'b1; vbc = 8'd70; data = gen_beat(8'h20);
        @(negedge clk);
        tick();
        val = 1'b0; sop = 1'b0; eop = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            ew = exp_word(8'h20, w, evb[w]);
            total++;
            if ({o_val, o_sop, o_eop} !== {1'b1, w == 0, w == 2}) begin
                bad++;
                $display("FAIL tail_flags w%0d: got val/sop/eop %b expected %b", w, {o_val, o_sop, o_eop}, {1'b1, w == 0, w == 2});
            end
            total++;
            if (int'(o_vbc) != evb[w]) begin
                bad++;
                $display("FAIL tail_vbc w%0d: got %0d expected %0d", w, o_vbc, evb[w]);
            end
            total++;
            if (o_data !== ew) begin
                bad++;
                $display("FAIL tail_data w%0d: got %h expected %h", w, o_data, ew);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (o_val !== 1'b0) begin
            bad++;
            $display("FAIL tail_end: got o_val %b expected 0", o_val);
        end
`ifdef UNPACKER_ZERO_PAD_EN
        total++;
        if (o_data !== '0) begin
            bad++;
            $display("FAIL tail_idle_zero: got %h expected 0", o_data);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        int cyc = 0;
        logic exp_rdy;
        logic hs;
        logic [OB*8-1:0] ew;
        tick();
        val = 1'b1; sop = 1'b1; eop = 1'b0; vbc = 8'd64; data = gen_beat(8'h40); o_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept1: got ready %b expected 1", ready);
        end
        tick();
        sop = 1'b0; eop = 1'b1; data = gen_beat(8'h80);
        while (idx < 4 && cyc < 20) begin
            o_rdy = (cyc % 2 == 1);
            @(negedge clk);
            exp_rdy = o_rdy && (idx == 1 || idx == 3);
            ew = exp_word((idx < 2) ? 8'h40 : 8'h80, idx % 2, 32);
            total++;
            if ({o_val, o_sop, o_eop, ready} !== {1'b1, idx == 0, idx == 3, exp_rdy}) begin
                bad++;
                $display("FAIL b2b_flags c%0d: got val/sop/eop/ready %b expected %b", cyc, {o_val, o_sop, o_eop, ready}, {1'b1, idx == 0, idx == 3, exp_rdy});
            end
            total++;
            if (o_data !== ew) begin
                bad++;
                $display("FAIL b2b_data c%0d: got %h expected %h", cyc, o_data, ew);
            end
            hs = o_rdy;
            tick();
            if (val && exp_rdy) val = 1'b0;
            if (hs) idx++;
            cyc++;
        end
        total++;
        if (idx != 4) begin
            bad++;
            $display("FAIL b2b_budget: got %0d words expected 4", idx);
        end
        o_rdy = 1'b1; eop = 1'b0;
        @(negedge clk);
        total++;
        if ({o_val, idle} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_end: got o_val/idle %b expected 01", {o_val, idle});
        end
    endtask

    task automatic test_gap;
        logic [OB*8-1:0] ew;
        tick();
        cfg_gap = 4'd3; o_rdy = 1'b1;
        val = 1'b1; sop = 1'b1; eop = 1'b1; vbc = 8'd32; data = gen_beat(8'h33);
        @(negedge clk);
        tick();
        data = gen_beat(8'h55);
        @(negedge clk);
        ew = exp_word(8'h33, 0, 32);
        total++;
        if ({o_val, ready} !== 2'b10 || o_data !== ew) begin
            bad++;
            $display("FAIL gap_first: got val/ready %b data %h expected 10 data %h", {o_val, ready}, o_data, ew);
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if ({o_val, ready} !== 2'b00) begin
                bad++;
                $display("FAIL gap_hold c%0d: got val/ready %b expected 00", c, {o_val, ready});
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({o_val, ready, idle} !== 3'b011) begin
            bad++;
            $display("FAIL gap_reopen: got val/ready/idle %b expected 011", {o_val, ready, idle});
        end
        tick();
        val = 1'b0; cfg_gap = '0;
        @(negedge clk);
        ew = exp_word(8'h55, 0, 32);
        total++;
        if ({o_val, o_sop} !== 2'b11 || o_data !== ew) begin
            bad++;
            $display("FAIL gap_second: got val/sop %b data %h expected 11 data %h", {o_val, o_sop}, o_data, ew);
        end
        tick();
        @(negedge clk);
        total++;
        if ({o_val, idle} !== 2'b01) begin
            bad++;
            $display("FAIL gap_end: got o_val/idle %b expected 01", {o_val, idle});
        end
    endtask

    task automatic test_oversize;
        int sum = 0;
        int errs = 0;
        logic [OB*8-1:0] ew;
        tick();
        val = 1'b1; sop = 1'b1; eop = 1'b1; vbc = 8'd200; data = gen_beat(8'h01);
        @(negedge clk);
        total++;
        if ({ready, err} !== 2'b11) begin
            bad++;
            $display("FAIL over_err: got ready/err %b expected 11", {ready, err});
        end
        tick();
        val = 1'b0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            sum += int'(o_vbc);
            if (err) errs++;
            ew = exp_word(8'h01, w, 32);
            total++;
            if (o_val !== 1'b1 || o_data !== ew) begin
                bad++;
                $display("FAIL over_word w%0d: got val %b data %h expected 1 data %h", w, o_val, o_data, ew);
            end
            tick();
        end
        total++;
        if (sum != 160 || errs != 0) begin
            bad++;
            $display("FAIL over_total: got bytes %0d extra_err %0d expected 160 and 0", sum, errs);
        end
        @(negedge clk);
        total++;
        if ({o_val, idle} !== 2'b01) begin
            bad++;
            $display("FAIL over_end: got o_val/idle %b expected 01", {o_val, idle});
        end
        tick();
        val = 1'b1; vbc = 8'd0; data = gen_beat(8'hA0);
        @(negedge clk);
        total++;
        if ({ready, err} !== 2'b10) begin
            bad++;
            $display("FAIL zero_accept: got ready/err %b expected 10", {ready, err});
        end
        tick();
        val = 1'b0; sop = 1'b0; eop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({o_val, idle} !== 2'b01) begin
                bad++;
                $display("FAIL zero_drop c%0d: got o_val/idle %b expected 01", c, {o_val, idle});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        logic [OB*8-1:0] ew;
        val = 1'b1; sop = 1'b1; eop = 1'b1; vbc = 8'd160; data = gen_beat(8'h60);
        @(negedge clk);
        tick();
        val = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        ew = exp_word(8'h60, 2, 32);
        total++;
        if (o_val !== 1'b1 || o_data !== ew) begin
            bad++;
            $display("FAIL mid_word2: got val %b data %h expected 1 data %h", o_val, o_data, ew);
        end
        #1 reset_L = 1'b0;
        #1;
        total++;
        if ({o_val, o_sop, o_eop, ready, idle, err} !== 6'b0 || o_vbc !== '0 || o_data !== '0) begin
            bad++;
            $display("FAIL mid_reset_out: got flags %b vbc %0d data %h expected all 0", {o_val, o_sop, o_eop, ready, idle, err}, o_vbc, o_data);
        end
        tick();
        tick();
        reset_L = 1'b1;
        @(negedge clk);
        total++;
        if ({ready, idle, o_val} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_cycle: got ready/idle/o_val %b expected 000", {ready, idle, o_val});
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({ready, idle, o_val} !== 3'b110) begin
                bad++;
                $display("FAIL mid_after c%0d: got ready/idle/o_val %b expected 110", c, {ready, idle, o_val});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_tail();
        test_back_to_back();
        test_gap();
        test_oversize();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
